// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU link framer (pack) and deframer (unpack).
// Holds the framing FSM states, sync bytes, field widths and the checksum step.
package ccu_pkg;

  localparam int CCU_LEN_W = 13;
  localparam int CCU_ID_W  = 16;

  localparam logic [7:0] CCU_SYNC0 = 8'hA5;
  localparam logic [7:0] CCU_SYNC1 = 8'h5A;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SYNC0 = 4'd1,
    S_SYNC1 = 4'd2,
    S_ID_H  = 4'd3,
    S_ID_L  = 4'd4,
    S_TYPE  = 4'd5,
    S_LEN_H = 4'd6,
    S_LEN_L = 4'd7,
    S_DATA  = 4'd8,
    S_CSUM  = 4'd9
  } ccu_state_e;

  // Modulo-256 running checksum step used on both sides of the link.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/ccu_pack_if.sv
// Framer bus: packet fields from the system FSM in, framed byte stream out.
// The slave modport is the framer; the master modport is its environment.
interface ccu_pack_if;
  import ccu_pkg::*;

  logic                 pack_dv;
  logic [CCU_ID_W-1:0]  pack_pack_id;
  logic [CCU_LEN_W-1:0] pack_pack_length;
  logic [7:0]           pack_pack_type;
  logic [7:0]           pack_pack_data;
  logic                 pack_busy;

  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output pack_dv, pack_pack_id, pack_pack_length, pack_pack_type, pack_pack_data,
    input  pack_busy,
    input  tx_data, tx_valid,
    output tx_ready
  );

  modport slave (
    input  pack_dv, pack_pack_id, pack_pack_length, pack_pack_type, pack_pack_data,
    output pack_busy,
    output tx_data, tx_valid,
    input  tx_ready
  );

endinterface

// File: rtl/ccu_pack.sv
// CCU transmit framer: sync, header, payload and checksum serialised onto a
// valid/ready byte stream. Outputs are decoded from registers only.
module ccu_pack
  import ccu_pkg::*;
#(
  parameter logic [7:0] SYNC0 = CCU_SYNC0,
  parameter logic [7:0] SYNC1 = CCU_SYNC1
) (
  input  logic       clk,
  input  logic       rstn,
  ccu_pack_if.slave  bus
);

  ccu_state_e           state_r, state_nxt_s;
  logic [CCU_ID_W-1:0]  id_r;
  logic [7:0]           type_r;
  logic [CCU_LEN_W-1:0] len_r;
  logic [7:0]           hold_r;
  logic                 hold_full_r;
  logic [CCU_LEN_W-1:0] acc_cnt_r;
  logic [CCU_LEN_W-1:0] sent_cnt_r;
  logic [7:0]           csum_r;

  logic                 busy_s;
  logic                 accept_s;
  logic                 beat_s;
  logic                 last_data_s;
  logic                 csum_en_s;
  logic [7:0]           tx_data_s;
  logic                 tx_valid_s;

  // Flow-control decode; busy never depends on pack_dv or tx_ready.
  always_comb begin
    busy_s = 1'b0;
    if (hold_full_r || (state_r == S_CSUM)) begin
      busy_s = 1'b1;
    end else if ((state_r != S_IDLE) && (acc_cnt_r == len_r)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  assign accept_s    = bus.pack_dv && !busy_s;
  assign beat_s      = tx_valid_s && bus.tx_ready;
  assign last_data_s = ((sent_cnt_r + 13'd1) == len_r);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: every framing state advances on its own output beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) state_nxt_s = S_SYNC0; else state_nxt_s = S_IDLE;
      S_SYNC0: if (beat_s) state_nxt_s = S_SYNC1; else state_nxt_s = S_SYNC0;
      S_SYNC1: if (beat_s) state_nxt_s = S_ID_H;  else state_nxt_s = S_SYNC1;
      S_ID_H:  if (beat_s) state_nxt_s = S_ID_L;  else state_nxt_s = S_ID_H;
      S_ID_L:  if (beat_s) state_nxt_s = S_TYPE;  else state_nxt_s = S_ID_L;
      S_TYPE:  if (beat_s) state_nxt_s = S_LEN_H; else state_nxt_s = S_TYPE;
      S_LEN_H: if (beat_s) state_nxt_s = S_LEN_L; else state_nxt_s = S_LEN_H;
      S_LEN_L: begin
        if (beat_s) begin
          state_nxt_s = (len_r != 13'd0) ? S_DATA : S_CSUM;
        end else begin
          state_nxt_s = S_LEN_L;
        end
      end
      S_DATA:  if (beat_s && last_data_s) state_nxt_s = S_CSUM; else state_nxt_s = S_DATA;
      S_CSUM:  if (beat_s) state_nxt_s = S_IDLE;  else state_nxt_s = S_CSUM;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode: tx byte and valid come straight from state and datapath registers.
  always_comb begin
    tx_data_s  = 8'h00;
    tx_valid_s = 1'b1;
    csum_en_s  = 1'b1;
    case (state_r)
      S_IDLE:  begin tx_data_s = 8'h00; tx_valid_s = 1'b0; csum_en_s = 1'b0; end
      S_SYNC0: begin tx_data_s = SYNC0; csum_en_s = 1'b0; end
      S_SYNC1: begin tx_data_s = SYNC1; csum_en_s = 1'b0; end
      S_ID_H:  tx_data_s = id_r[15:8];
      S_ID_L:  tx_data_s = id_r[7:0];
      S_TYPE:  tx_data_s = type_r;
      S_LEN_H: tx_data_s = {3'b000, len_r[12:8]};
      S_LEN_L: tx_data_s = len_r[7:0];
      S_DATA:  begin tx_data_s = hold_r; tx_valid_s = hold_full_r; end
      S_CSUM:  begin tx_data_s = csum_r; csum_en_s = 1'b0; end
      default: begin tx_data_s = 8'h00; tx_valid_s = 1'b0; csum_en_s = 1'b0; end
    endcase
  end

  assign bus.pack_busy = busy_s;
  assign bus.tx_data   = tx_data_s;
  assign bus.tx_valid  = tx_valid_s;

  // Datapath: header latch, payload hold register, counters and checksum.
  // An accept and a header beat may coincide; in DATA they are mutually exclusive
  // because an accept needs an empty hold register and a beat needs a full one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_r        <= 16'h0000;
      type_r      <= 8'h00;
      len_r       <= 13'd0;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      acc_cnt_r   <= 13'd0;
      sent_cnt_r  <= 13'd0;
      csum_r      <= 8'h00;
    end else begin
      if (accept_s) begin
        if (state_r == S_IDLE) begin
          id_r       <= bus.pack_pack_id;
          type_r     <= bus.pack_pack_type;
          len_r      <= bus.pack_pack_length;
          csum_r     <= 8'h00;
          sent_cnt_r <= 13'd0;
          if (bus.pack_pack_length != 13'd0) begin
            hold_r      <= bus.pack_pack_data;
            hold_full_r <= 1'b1;
            acc_cnt_r   <= 13'd1;
          end else begin
            acc_cnt_r   <= 13'd0;
          end
        end else begin
          hold_r      <= bus.pack_pack_data;
          hold_full_r <= 1'b1;
          acc_cnt_r   <= acc_cnt_r + 13'd1;
        end
      end
      if (beat_s) begin
        if (csum_en_s) begin
          csum_r <= csum_add(csum_r, tx_data_s);
        end
        if (state_r == S_DATA) begin
          hold_full_r <= 1'b0;
          sent_cnt_r  <= sent_cnt_r + 13'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccu_pack.sv
// Directed bench for ccu_pack: hand-computed frames, stall, max length and
// mid-packet reset, checked against constants and a small frame model.
module tb_ccu_pack;

  logic clk;
  logic rstn;
  int   tests_run;
  int   tests_failed;

  ccu_pack_if bus ();

  ccu_pack dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] stall_data_q[$];
  logic       stall_valid_q[$];
  int         n_acc;
  bit         timed_out;

  // Reference frame built from the packet fields alone.
  function automatic void build_exp(input logic [15:0] id, input logic [7:0] typ,
                                    input int len, input logic [7:0] base);
    logic [7:0] sum;
    logic [12:0] l13;
    l13 = len[12:0];
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(id[15:8]);
    exp_q.push_back(id[7:0]);
    exp_q.push_back(typ);
    exp_q.push_back({3'b000, l13[12:8]});
    exp_q.push_back(l13[7:0]);
    for (int i = 0; i < len; i++) exp_q.push_back(base + i[7:0]);
    sum = 8'h00;
    for (int i = 2; i < exp_q.size(); i++) sum = sum + exp_q[i];
    exp_q.push_back(sum);
  endfunction

  // Sender holds pack_dv high throughout and scrambles header fields after the
  // first accept; the sink stalls stall_n cycles once stall_at bytes are out.
  // Returns after the whole frame, or once abort_at bytes have been collected.
  task automatic send_frame(input logic [15:0] id, input logic [7:0] typ, input int len,
                            input logic [7:0] base, input int stall_at, input int stall_n,
                            input int abort_at);
    int  cycles;
    int  budget;
    int  stall_left;
    bit  acc;
    bit  beat;
    logic [7:0] byte_s;
    got_q.delete();
    stall_data_q.delete();
    stall_valid_q.delete();
    n_acc      = 0;
    timed_out  = 1'b0;
    cycles     = 0;
    stall_left = stall_n;
    budget     = 4 * (len + 12) + stall_n + 20;
    bus.pack_dv          = 1'b1;
    bus.pack_pack_id     = id;
    bus.pack_pack_type   = typ;
    bus.pack_pack_length = len[12:0];
    bus.pack_pack_data   = (len > 0) ? base : 8'hEE;
    while ((got_q.size() < len + 8) && (got_q.size() != abort_at) && !timed_out) begin
      if ((got_q.size() == stall_at) && (stall_left > 0) && bus.tx_valid) begin
        bus.tx_ready = 1'b0;
        stall_data_q.push_back(bus.tx_data);
        stall_valid_q.push_back(bus.tx_valid);
        stall_left--;
      end else begin
        bus.tx_ready = 1'b1;
      end
      acc    = bus.pack_dv && !bus.pack_busy;
      beat   = bus.tx_valid && bus.tx_ready;
      byte_s = bus.tx_data;
      @(posedge clk);
      #1;
      if (beat) got_q.push_back(byte_s);
      if (acc) begin
        n_acc++;
        bus.pack_pack_id     = ~id;
        bus.pack_pack_type   = ~typ;
        bus.pack_pack_length = 13'h0AA5;
        bus.pack_pack_data   = (n_acc < len) ? base + n_acc[7:0] : 8'hEE;
      end
      cycles++;
      if (cycles >= budget) timed_out = 1'b1;
    end
    bus.pack_dv  = 1'b0;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.pack_dv = 1'b0;
    bus.pack_pack_id = 16'h0000;
    bus.pack_pack_type = 8'h00;
    bus.pack_pack_length = 13'd0;
    bus.pack_pack_data = 8'h00;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    tests_run++;
    if (bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    tests_run++;
    if (bus.pack_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.pack_busy); end
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] ref_v[11];
    int bad;
    ref_v = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h07, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h56};
    send_frame(16'h1234, 8'h07, 3, 8'h01, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 11; i++) if (i >= got_q.size() || got_q[i] !== ref_v[i]) bad++;
    tests_run++;
    if (timed_out || got_q.size() != 11 || bad != 0) begin
      tests_failed++; $display("FAIL basic_stream got_len=%0d bad=%0d exp_len=11 timeout=%0d", got_q.size(), bad, timed_out);
    end
    tests_run++;
    if (n_acc != 3) begin tests_failed++; $display("FAIL basic_accepts got=%0d exp=3", n_acc); end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.pack_busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_idle busy=%b valid=%b exp=0,0", bus.pack_busy, bus.tx_valid);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] ref_v[8];
    int bad;
    ref_v = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
    send_frame(16'h0001, 8'hFF, 0, 8'h00, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 8; i++) if (i >= got_q.size() || got_q[i] !== ref_v[i]) bad++;
    tests_run++;
    if (timed_out || got_q.size() != 8 || bad != 0) begin
      tests_failed++; $display("FAIL zero_len_stream got_len=%0d bad=%0d exp_len=8 timeout=%0d", got_q.size(), bad, timed_out);
    end
    tests_run++;
    if (n_acc != 1) begin tests_failed++; $display("FAIL zero_len_accepts got=%0d exp=1", n_acc); end
  endtask

  task automatic test_stall();
    int bad;
    send_frame(16'h1234, 8'h07, 3, 8'h01, 3, 5, -1);
    bad = 0;
    for (int i = 0; i < stall_data_q.size(); i++)
      if (stall_data_q[i] !== 8'h34 || stall_valid_q[i] !== 1'b1) bad++;
    tests_run++;
    if (stall_data_q.size() != 5 || bad != 0) begin
      tests_failed++; $display("FAIL stall_hold cycles=%0d bad=%0d exp_cycles=5 exp_data=34", stall_data_q.size(), bad);
    end
    build_exp(16'h1234, 8'h07, 3, 8'h01);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (timed_out || got_q.size() != exp_q.size() || bad != 0) begin
      tests_failed++; $display("FAIL stall_stream got_len=%0d bad=%0d exp_len=%0d", got_q.size(), bad, exp_q.size());
    end
  endtask

  task automatic test_max_len();
    int bad;
    send_frame(16'hBEEF, 8'h3C, 8191, 8'h00, -1, 0, -1);
    build_exp(16'hBEEF, 8'h3C, 8191, 8'h00);
    tests_run++;
    if (got_q.size() != 8199) begin tests_failed++; $display("FAIL max_len_size got=%0d exp=8199", got_q.size()); end
    tests_run++;
    if (got_q.size() < 7 || got_q[5] !== 8'h1F || got_q[6] !== 8'hFF) begin
      tests_failed++; $display("FAIL max_len_len_bytes got_size=%0d exp=1F,FF", got_q.size());
    end
    bad = 0;
    for (int i = 7; i < 8198; i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0 || n_acc != 8191) begin
      tests_failed++; $display("FAIL max_len_data bad=%0d accepts=%0d exp=0,8191", bad, n_acc);
    end
    tests_run++;
    if (got_q.size() != 8199 || got_q[8198] !== exp_q[8198]) begin
      tests_failed++; $display("FAIL max_len_csum got_size=%0d exp=%h", got_q.size(), exp_q[8198]);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    send_frame(16'h1234, 8'h07, 3, 8'h01, -1, 0, 8);
    tests_run++;
    if (timed_out || got_q.size() != 8) begin
      tests_failed++; $display("FAIL mid_reach_data got_len=%0d exp=8", got_q.size());
    end
    #2;
    rstn = 1'b0;
    #1;
    tests_run++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.pack_busy !== 1'b0) begin
      tests_failed++; $display("FAIL mid_async_reset valid=%b data=%h busy=%b exp=0,00,0", bus.tx_valid, bus.tx_data, bus.pack_busy);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16'hC0DE, 8'h11, 2, 8'h80, -1, 0, -1);
    build_exp(16'hC0DE, 8'h11, 2, 8'h80);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (timed_out || got_q.size() != exp_q.size() || bad != 0) begin
      tests_failed++; $display("FAIL mid_fresh_stream got_len=%0d bad=%0d exp_len=%0d", got_q.size(), bad, exp_q.size());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_max_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
